// File: rtl/ser_add_pkg.sv
// Shared helpers for the serial adder slice: sizing of the pair counter.
package ser_add_pkg;

    // Pair counter needs to index W/2 pairs but is never narrower than one bit.
    function automatic int pair_cnt_w(input int w);
        return (w / 2 <= 1) ? 1 : $clog2(w / 2);
    endfunction

endpackage

// File: rtl/ser_add_add2b.sv
// Two-bit ripple full-adder slice built from two fac cells.
module add2b (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic c1;

    fac u_fac0 (.a(a[0]), .b(b[0]), .ci(ci), .s(s[0]), .co(c1));
    fac u_fac1 (.a(a[1]), .b(b[1]), .ci(c1), .s(s[1]), .co(co));

endmodule

// File: rtl/ser_add_fac.sv
// Single-bit full adder cell.
module fac (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/ser_add.sv
// Serial adder: {co,sum} = x + y + ci, two bits per cycle through one add2b slice.
module ser_add
    import ser_add_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         co
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int            CW   = pair_cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

    state_t        state;
    logic [W-1:0]  xs;
    logic [W-1:0]  ys;
    logic          c;
    logic [CW-1:0] cnt;
    logic [1:0]    slice_sum;
    logic          slice_co;

    add2b u_slice (
        .a (xs[1:0]),
        .b (ys[1:0]),
        .ci(c),
        .s (slice_sum),
        .co(slice_co)
    );

    // Each RUN edge retires one operand pair; the result fills sum from the top
    // so the LSB pair ends up at the bottom after the last pair.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
            xs    <= '0;
            ys    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xs    <= x;
                        ys    <= y;
                        c     <= ci;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum <= (sum >> 2) | (W'(slice_sum) << (W - 2));
                    xs  <= xs >> 2;
                    ys  <= ys >> 2;
                    c   <= slice_co;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        co    <= slice_co;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_add.sv
// Bench for ser_add: an 8-bit instance for directed vectors and a 4-bit instance
// swept exhaustively, both tracked by a cycle-count model of the handshake.
module tb_ser_add;

    localparam int H8 = 4;
    localparam int H4 = 2;

    logic       clk;
    logic       rst_b;
    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] x8, y8, sum8;
    logic       start4, ci4, busy4, done4, co4;
    logic [3:0] x4, y4, sum4;

    int total;
    int bad;

    ser_add #(.W(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .x(x8), .y(y8), .ci(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .co(co8)
    );

    ser_add #(.W(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .x(x4), .y(y4), .ci(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .co(co4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: phase counts edges since the accepted start (0 = idle); the
    // result is the plain arithmetic sum and becomes visible at phase H+1.
    int         ph8, ph4;
    logic [8:0] res8, last8;
    logic [4:0] res4, last4;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ph8   = 0;
            last8 = '0;
        end else if (ph8 == 0) begin
            if (start8) begin
                res8 = {1'b0, x8} + {1'b0, y8} + 9'(ci8);
                ph8  = 1;
            end
        end else if (ph8 <= H8) begin
            ph8++;
            if (ph8 == H8 + 1) last8 = res8;
        end else begin
            ph8 = 0;
        end
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ph4   = 0;
            last4 = '0;
        end else if (ph4 == 0) begin
            if (start4) begin
                res4 = {1'b0, x4} + {1'b0, y4} + 5'(ci4);
                ph4  = 1;
            end
        end else if (ph4 <= H4) begin
            ph4++;
            if (ph4 == H4 + 1) last4 = res4;
        end else begin
            ph4 = 0;
        end
    end

    always @(negedge clk) begin
        checkOutput("busy8", 32'(busy8), 32'(ph8 != 0));
        checkOutput("done8", 32'(done8), 32'(ph8 == H8 + 1));
        if (ph8 == 0 || ph8 == H8 + 1) checkOutput("result8", 32'({co8, sum8}), 32'(last8));
        checkOutput("busy4", 32'(busy4), 32'(ph4 != 0));
        checkOutput("done4", 32'(done4), 32'(ph4 == H4 + 1));
        if (ph4 == 0 || ph4 == H4 + 1) checkOutput("result4", 32'({co4, sum4}), 32'(last4));
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input logic [7:0] esum, input logic eco,
                                 input bit scramble, input bit restart);
        int n;
        int dones;
        @(negedge clk);
        x8 = a; y8 = b; ci8 = cin; start8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start8 = 1'b0;
                if (scramble) begin x8 = 8'hFF; y8 = 8'hFF; ci8 = 1'b1; end
            end
            if (restart && n == 2) begin start8 = 1'b1; x8 = 8'h11; y8 = 8'h22; end
            if (restart && n == 3) start8 = 1'b0;
        end while (!done8 && n < 20);
        checkOutput("latency8", 32'(n), 32'd5);
        checkOutput("sum8_lit", 32'(sum8), 32'(esum));
        checkOutput("co8_lit", 32'(co8), 32'(eco));
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checkOutput("extra_done8", 32'(dones), 32'd0);
        checkOutput("idle_busy8", 32'(busy8), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        total = 0; bad = 0;
        rst_b = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0; ci8 = 1'b0;
        start4 = 1'b0; x4 = '0; y4 = '0; ci4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_res", 32'({co8, sum8}), 32'd0);
        rst_b = 1'b1;

        applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("model_pin_ff01", 32'(last8), 32'h100);
        applyStimulus(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0);
        checkOutput("model_pin_1234", 32'(last8), 32'h047);
        applyStimulus(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);

        // start held high: back-to-back operations, one idle cycle between them
        @(negedge clk);
        x8 = 8'h21; y8 = 8'h43; ci8 = 1'b0; start8 = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        start8 = 1'b0;
        checkOutput("held_start_dones", 32'(dones), 32'd2);
        checkOutput("held_start_sum", 32'(sum8), 32'h64);

        // reset in the middle of an operation
        @(negedge clk);
        x8 = 8'hF0; y8 = 8'h0F; ci8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy8), 32'd0);
        checkOutput("midrst_done", 32'(done8), 32'd0);
        checkOutput("midrst_res", 32'({co8, sum8}), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checkOutput("post_rst_dones", 32'(dones), 32'd0);
        applyStimulus(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 1'b0, 1'b0);

        // exhaustive sweep of the 4-bit instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    x4 = 4'(a); y4 = 4'(b); ci4 = 1'(c); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    n = 1;
                    while (!done4 && n < 10) begin
                        @(negedge clk);
                        n++;
                    end
                    checkOutput("latency4", 32'(n), 32'd3);
                    checkOutput("sweep4", 32'({co4, sum4}), 32'(a + b + c));
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
